seg7_multi_display: RTL and testbench

- Parametrised successor to the fixed six-digit time display driver for the DE10-lite seven-segment bank.
- Accepts an arbitrary binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine, one bit per clock.
- Drives NDIGITS active-low seven-segment digits with per-digit decimal-point, blink and leading-zero blanking control.
- Sits between the counters/datapath and the board HEX pins; replaces per-field hard-coded case decoding.

---
 rtl/seg7_multi_display.sv | 177 +++++++++++++++++
 tb/tb_seg7_multi_display.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// Binary-to-BCD (double-dabble, one bit per clock) seven-segment driver for NDIGITS active-low digits.
// Optional SEG7_HEX_DISPLAY_EN adds hex_mode: raw-nibble display that bypasses the conversion.
module seg7_multi_display #(
    parameter int NDIGITS   = 6,
    parameter int VALW      = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef SEG7_HEX_DISPLAY_EN
    input  logic                   hex_mode,
`endif
    input  logic [VALW-1:0]        value,
    input  logic                   load,
    output logic                   ready,
    input  logic [NDIGITS-1:0]     dp_mask,
    input  logic [NDIGITS-1:0]     blink_mask,
    input  logic                   lz_blank,
    output logic                   overflow,
    output logic [8*NDIGITS-1:0]   seg
);
    localparam int DW = 4 * NDIGITS;
    localparam int CW = $clog2(VALW + 1);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state;
    logic [VALW-1:0] shreg;
    logic [DW-1:0]   bcd;
    logic [DW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic [DW-1:0]   disp;
    logic            disp_vld;
    logic [BW-1:0]   bcnt;
    logic            blink_phase;

`ifdef SEG7_HEX_DISPLAY_EN
    localparam int XW = (VALW > DW) ? VALW : DW;
    logic [XW-1:0] vext;
    assign vext = XW'(value);
`endif

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // A carry out of the top digit means the value needs more digits than we have.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            disp     <= '0;
            disp_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        ready <= 1'b0;
`ifdef SEG7_HEX_DISPLAY_EN
                        if (hex_mode) begin
                            bcd   <= vext[DW-1:0];
                            ovf   <= |(vext >> DW);
                            state <= COMMIT;
                        end else
`endif
                        begin
                            shreg <= value;
                            bcd   <= '0;
                            ovf   <= 1'b0;
                            cnt   <= CW'(VALW);
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd   <= {adj[DW-2:0], shreg[VALW-1]};
                    shreg <= shreg << 1;
                    if (adj[DW-1])
                        ovf <= 1'b1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp     <= bcd;
                    disp_vld <= 1'b1;
                    overflow <= ovf;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt        <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
`ifdef SEG7_HEX_DISPLAY_EN
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    logic [8*NDIGITS-1:0] seg_next;
    logic                 lead;
    logic [3:0]           nib;
    logic [6:0]           glyph;

    // Walk from the most significant digit so "lead" tracks whether all higher digits are zero.
    always_comb begin
        seg_next = '1;
        lead     = lz_blank;
        nib      = '0;
        glyph    = 7'h7F;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            nib = disp[4*i +: 4];
            if (nib != 4'd0)
                lead = 1'b0;
            if (overflow)
                glyph = 7'h3F;
            else if (lead && i != 0)
                glyph = 7'h7F;
            else
                glyph = decode(nib);
            if (!disp_vld || (blink_phase && blink_mask[i]))
                seg_next[8*i +: 8] = 8'hFF;
            else
                seg_next[8*i +: 8] = {~dp_mask[i], glyph};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seg <= '1;
        else
            seg <= seg_next;
    end
endmodule

// File: tb/tb_seg7_multi_display.sv
module tb_seg7_multi_display;
    localparam int ND = 6;
    localparam int VW = 20;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hex_mode;
    logic [VW-1:0] value;
    logic          load;
    logic          ready;
    logic [ND-1:0] dp_mask;
    logic [ND-1:0] blink_mask;
    logic          lz_blank;
    logic          overflow;
    logic [8*ND-1:0] seg;

    always #5 clk = ~clk;

    seg7_multi_display #(.NDIGITS(ND), .VALW(VW), .BLINK_DIV(BD)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SEG7_HEX_DISPLAY_EN
        .hex_mode(hex_mode),
`endif
        .value(value),
        .load(load),
        .ready(ready),
        .dp_mask(dp_mask),
        .blink_mask(blink_mask),
        .lz_blank(lz_blank),
        .overflow(overflow),
        .seg(seg)
    );

    typedef struct {
        logic [47:0] seg;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] glyph_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference: digits from plain arithmetic (v / 10^i), blanking from "nothing left above".
    function automatic logic [47:0] model(input int unsigned v, input logic [5:0] dp,
                                          input logic lz, input bit hex, output logic ovf);
        logic [47:0] m;
        logic [7:0]  g;
        int unsigned p, d, hi;
        p   = 1;
        ovf = hex ? ((v >> 24) != 0) : (v > 999999);
        for (int i = 0; i < 6; i++) begin
            hi = hex ? (v >> (4*i)) : (v / p);
            d  = hex ? (hi & 15) : (hi % 10);
            if (ovf) g = 8'hBF;
            else if (lz && i > 0 && hi == 0) g = 8'hFF;
            else g = glyph_of(int'(d));
            g[7] = ~dp[i];
            m[8*i +: 8] = g;
            p = p * 10;
        end
        return m;
    endfunction

    task automatic do_load(input int unsigned v, input bit hex);
        exp_t e;
        logic o;
        @(negedge clk);
        value    = v[VW-1:0];
        hex_mode = hex;
        load     = 1'b1;
        if (ready) begin
            e.seg = model(v, dp_mask, lz_blank, hex, o);
            e.ovf = o;
            e.lat = hex ? 1 : VW + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        load     = 1'b0;
        hex_mode = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: a ready rise marks a commit; the new display is visible one edge later.
    logic mon_prev = 1'b1;
    int   mon_low  = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 1'b1;
                mon_low  = 0;
            end else if (!ready) begin
                mon_low++;
                mon_prev = 1'b0;
            end else if (!mon_prev) begin
                mon_prev = 1'b1;
                @(posedge clk);
                #1;
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_commit: seg=%h with nothing outstanding", seg);
                end else begin
                    e = sbq.pop_front();
                    check("seg", 64'(seg), 64'(e.seg));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("ready_low_cycles", 64'(mon_low), 64'(e.lat));
                end
                mon_low = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          run;
        int          runs;
        logic        prev_dark;
        logic        dark;
        int unsigned v;
        rst_n = 1'b0; load = 1'b0; value = '0; hex_mode = 1'b0;
        dp_mask = '0; blink_mask = '0; lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_seg", 64'(seg), 64'(48'hFFFF_FFFF_FFFF));
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_overflow", 64'(overflow), 64'd0);

        do_load(123456, 0); drain();
        lz_blank = 1'b1;
        do_load(42, 0); drain();
        do_load(0, 0); drain();
        lz_blank = 1'b0;
        do_load(1048575, 0); drain();
        do_load(7, 0); drain();

        for (int k = 0; k < 20; k++) begin
            dp_mask  = ND'($urandom);
            lz_blank = 1'($urandom);
            case ($urandom_range(0, 2))
                0: v = $urandom_range(0, 999999);
                1: v = $urandom_range(0, 999);
                default: v = $urandom_range(0, 1048575);
            endcase
            do_load(v, 0); drain();
        end
        dp_mask = '0; lz_blank = 1'b0;

        // A second load while busy must be dropped.
        do_load(111111, 0);
        repeat (3) @(negedge clk);
        do_load(222222, 0);
        drain();

        // Reset mid-conversion aborts it and darkens the display.
        do_load(555555, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_seg", 64'(seg), 64'(48'hFFFF_FFFF_FFFF));
        check("midreset_ready", 64'(ready), 64'd1);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_dark", 64'(seg), 64'(48'hFFFF_FFFF_FFFF));
        check("post_reset_ready", 64'(ready), 64'd1);
        do_load(123456, 0); drain();

        // Blink digits 1,0; digit 2 keeps its decimal point lit.
        dp_mask = 6'b000100; blink_mask = 6'b000011;
        repeat (2) @(negedge clk);
        run = 0; runs = 0; prev_dark = (seg[7:0] == 8'hFF);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("blink_upper", 64'(seg[47:16]), 64'(32'hF9A4_B019));
            check("blink_pair", 64'(seg[15:0] == 16'hFFFF || seg[15:0] == 16'h9282), 64'd1);
            dark = (seg[7:0] == 8'hFF);
            run++;
            if (dark != prev_dark) begin
                if (runs > 0) check("blink_run_len", 64'(run), 64'(BD));
                runs++;
                run = 0;
                prev_dark = dark;
            end
        end
        check("blink_toggled", 64'(runs >= 5), 64'd1);
        blink_mask = '0; dp_mask = '0;
        repeat (2) @(negedge clk);

`ifdef SEG7_HEX_DISPLAY_EN
        do_load(20'hABCDE, 1); drain();
        for (int k = 0; k < 5; k++) begin
            dp_mask = ND'($urandom);
            do_load($urandom_range(0, 1048575), 1); drain();
        end
        dp_mask = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
